// File: rtl/hazard_forward_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_if
// Decode-side bundle between the pipeline control and the hazard/forward
// unit.
//   master (pipeline): drives the decode operands and flush, and reads back
//                      stall/bubble, the forward selects and the stall count.
//   slave  (hazard unit): the reverse directions.
// Decode operands: Rn_0, Rm_0, useRn_0, useRm_0, Rd_0, RegWrite_0,
//                  MemRead_0, flush
// Results:         stall, bubble, fwdA, fwdB, stallCount
// ---------------------------------------------------------------------------
interface hazard_forward_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       Rn_0;
   logic [4:0]       Rm_0;
   logic             useRn_0;
   logic             useRm_0;
   logic [4:0]       Rd_0;
   logic             RegWrite_0;
   logic             MemRead_0;
   logic             flush;
   logic             stall;
   logic             bubble;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;
   logic [CNT_W-1:0] stallCount;

   modport master (
      output Rn_0, Rm_0, useRn_0, useRm_0, Rd_0, RegWrite_0, MemRead_0, flush,
      input  stall, bubble, fwdA, fwdB, stallCount
   );

   modport slave (
      input  Rn_0, Rm_0, useRn_0, useRm_0, Rd_0, RegWrite_0, MemRead_0, flush,
      output stall, bubble, fwdA, fwdB, stallCount
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
// Load-use stall detection and EX-stage operand forwarding for a five-stage
// pipeline. A shadow copy of the EX and MEM destination/flag fields is kept
// here so that the unit does not depend on the datapath's control registers.
//   clk    : pipeline clock
//   reset  : asynchronous, active-low reset
//   hz     : slave side of hazard_forward_unit_if
//            stall/bubble are combinational from the decode operands;
//            fwdA/fwdB are registered and line up with the ID/EX outputs;
//            stallCount is a saturating count of stall cycles.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_forward_unit_if.slave hz
);

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,   // register file read (Da/Db)
      FWD_EX_MEM = 2'b01,   // EX/MEM ALU_Out
      FWD_MEM_WB = 2'b10    // MEM/WB writeback data
   } fwd_sel_e;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } ex_slot_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
   } mem_slot_t;

   localparam logic [4:0]       XZR     = 5'd31;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // The WB stage is not shadowed: the register file writes through, so a
   // WB-stage producer is already visible to the decode-stage read.
   ex_slot_t         ex_q;
   mem_slot_t        mem_q;
   fwd_sel_e         fwd_a_q;
   fwd_sel_e         fwd_b_q;
   logic [CNT_W-1:0] stall_count_q;

   logic     stall_d;
   logic     bubble_d;
   fwd_sel_e fwd_a_d;
   fwd_sel_e fwd_b_d;

   // A producer matches a live source; XZR never matches on either side.
   function automatic logic producer_match(input logic [4:0] rd,
                                           input logic       reg_write,
                                           input logic [4:0] src,
                                           input logic       live);
      return live && reg_write && (rd == src) && (rd != XZR);
   endfunction

   // The EX slot is the youngest producer, so it wins over MEM. A load in EX
   // cannot be forwarded from EX/MEM; that case is a stall instead.
   function automatic fwd_sel_e select_fwd(input logic ex_hit,
                                           input logic ex_load,
                                           input logic mem_hit);
      if (ex_hit && !ex_load) begin
         return FWD_EX_MEM;
      end else if (mem_hit) begin
         return FWD_MEM_WB;
      end
      return FWD_RF;
   endfunction

   always_comb begin
      logic rn_live, rm_live;
      logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
      // NOTE: every output of this block gets a default first so no path can
      // leave it unassigned and infer a latch.
      stall_d  = 1'b0;
      bubble_d = 1'b0;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;

      rn_live   = hz.useRn_0 && (hz.Rn_0 != XZR);
      rm_live   = hz.useRm_0 && (hz.Rm_0 != XZR);
      ex_hit_a  = producer_match(ex_q.rd,  ex_q.reg_write,  hz.Rn_0, rn_live);
      ex_hit_b  = producer_match(ex_q.rd,  ex_q.reg_write,  hz.Rm_0, rm_live);
      mem_hit_a = producer_match(mem_q.rd, mem_q.reg_write, hz.Rn_0, rn_live);
      mem_hit_b = producer_match(mem_q.rd, mem_q.reg_write, hz.Rm_0, rm_live);

      // Flush kills the decode instruction, so any hazard it had is moot.
      stall_d  = ex_q.mem_read && (ex_hit_a || ex_hit_b) && !hz.flush;
      bubble_d = stall_d || hz.flush;
      fwd_a_d  = select_fwd(ex_hit_a, ex_q.mem_read, mem_hit_a);
      fwd_b_d  = select_fwd(ex_hit_b, ex_q.mem_read, mem_hit_b);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others (the EX->MEM shift relies on it).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q          <= '0;
         mem_q         <= '0;
         fwd_a_q       <= FWD_RF;
         fwd_b_q       <= FWD_RF;
         stall_count_q <= '0;
      end else begin
         mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
         if (bubble_d) begin
            ex_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
         end else begin
            ex_q    <= '{rd: hz.Rd_0, reg_write: hz.RegWrite_0,
                         mem_read: hz.MemRead_0};
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
         end
         if (stall_d && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_ONE;
         end
      end
   end

   assign hz.stall      = stall_d;
   assign hz.bubble     = bubble_d;
   assign hz.fwdA       = fwd_a_q;
   assign hz.fwdB       = fwd_b_q;
   assign hz.stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
// Directed instruction sequences for hazard_forward_unit. The driver presents
// one decode instruction per cycle and queues the expected combinational
// result for that cycle and the expected registered result for the next
// cycle; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

   localparam int CNT_W = 8;
   localparam int SAT   = (1 << CNT_W) - 1;

   typedef struct {
      int         cyc;
      string      name;
      bit         chk_comb;
      bit         stall;
      bit         bubble;
      bit         chk_reg;
      logic [1:0] fa;
      logic [1:0] fb;
      int         cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   hazard_forward_unit_if #(.CNT_W(CNT_W)) hz_if ();

   hazard_forward_unit #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.chk_comb) begin
            check($sformatf("%s@%0d stall", e.name, e.cyc), int'(hz_if.stall), int'(e.stall));
            check($sformatf("%s@%0d bubble", e.name, e.cyc), int'(hz_if.bubble), int'(e.bubble));
         end
         if (e.chk_reg) begin
            check($sformatf("%s@%0d fwdA", e.name, e.cyc), int'(hz_if.fwdA), int'(e.fa));
            check($sformatf("%s@%0d fwdB", e.name, e.cyc), int'(hz_if.fwdB), int'(e.fb));
            check($sformatf("%s@%0d stallCount", e.name, e.cyc), int'(hz_if.stallCount), e.cnt);
         end
      end
   end

   task automatic drive(input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl);
      hz_if.Rn_0       = rn;
      hz_if.Rm_0       = rm;
      hz_if.useRn_0    = urn;
      hz_if.useRm_0    = urm;
      hz_if.Rd_0       = rd;
      hz_if.RegWrite_0 = rw;
      hz_if.MemRead_0  = mr;
      hz_if.flush      = fl;
   endtask

   // One decode cycle: present the instruction, queue the same-cycle stall /
   // bubble expectation and the next-cycle forward / counter expectation.
   task automatic issue(input string name,
                        input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl,
                        input logic e_stall, input logic [1:0] e_fa,
                        input logic [1:0] e_fb, input int e_cnt,
                        input bit reg_chk = 1'b1);
      exp_t e;
      drive(rn, rm, urn, urm, rd, rw, mr, fl);
      e = '{cyc: cyc, name: name, chk_comb: 1'b1, stall: e_stall,
            bubble: e_stall | fl, chk_reg: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 0};
      sb.push_back(e);
      if (reg_chk) begin
         e = '{cyc: cyc + 1, name: name, chk_comb: 1'b0, stall: 1'b0,
               bubble: 1'b0, chk_reg: 1'b1, fa: e_fa, fb: e_fb, cnt: e_cnt};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      int   n_stalls;
      int   stalls_so_far;
      reset = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      //      name            rn  rm  urn urm rd  rw mr fl  stall fa     fb     cnt
      issue("in_reset",       0,  0,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 0);
      reset = 1'b1;
      issue("idle",           0,  0,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 0);

      // Back-to-back ALU dependency: EX/MEM forward, no stall.
      issue("add_x1",         0,  0,  0,  0,  1,  1, 0, 0,  0,    2'b00, 2'b00, 0);
      issue("sub_rn_x1",      1,  5,  1,  1,  6,  1, 0, 0,  0,    2'b01, 2'b00, 0);

      // Load-use: one stall cycle, then MEM/WB forward.
      issue("ldur_x2",        7,  0,  1,  0,  2,  1, 1, 0,  0,    2'b00, 2'b00, 0);
      issue("add_rm_x2",      9,  2,  1,  1,  8,  1, 0, 0,  1,    2'b00, 2'b00, 1);
      issue("add_rm_x2_held", 9,  2,  1,  1,  8,  1, 0, 0,  0,    2'b00, 2'b10, 1);

      // Two producers of X3: the younger (EX) wins on both operands.
      issue("add_x3_a",       0,  0,  0,  0,  3,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("add_x3_b",       0,  0,  0,  0,  3,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("rd_x3_both",     3,  3,  1,  1, 10,  1, 0, 0,  0,    2'b01, 2'b01, 1);

      // XZR never forwards or stalls, whether written by ALU op or load.
      issue("add_x31",        0,  0,  0,  0, 31,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("rd_x31",        31, 31,  1,  1,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("ldur_x31",       0,  0,  0,  0, 31,  1, 1, 0,  0,    2'b00, 2'b00, 1);
      issue("rd_x31_ld",     31, 31,  1,  1,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);

      // Load, independent op, dependent op: no stall, MEM/WB forward.
      issue("ldur_x4",        0,  0,  0,  0,  4,  1, 1, 0,  0,    2'b00, 2'b00, 1);
      issue("indep",         13,  0,  1,  0, 12,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("dep_x4",         4,  0,  1,  0,  0,  0, 0, 0,  0,    2'b10, 2'b00, 1);

      // Producer already in WB at decode: write-through, no forward.
      issue("add_x14",        0,  0,  0,  0, 14,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("nop_a",          0,  0,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("nop_b",          0,  0,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("rd_x14_wb",     14, 14,  1,  1,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);

      // Matching register numbers with use flags clear do not forward.
      issue("add_x15",        0,  0,  0,  0, 15,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("rd_x15_unused", 15, 15,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 1);

      // Flush on top of a load-use hazard: no stall, bubble, count unchanged.
      issue("ldur_x5",        0,  0,  0,  0,  5,  1, 1, 0,  0,    2'b00, 2'b00, 1);
      issue("flush_rd_x5",    5,  0,  1,  0,  0,  0, 0, 1,  0,    2'b00, 2'b00, 1);
      issue("rd_x5_after",    5,  0,  1,  0,  0,  0, 0, 0,  0,    2'b10, 2'b00, 1);

      // Asynchronous reset in the middle of a stall cycle. fwdA is 01 going
      // into the stall cycle and stallCount is 1; both must clear at once.
      issue("add_x2",         0,  0,  0,  0,  2,  1, 0, 0,  0,    2'b00, 2'b00, 1);
      issue("ldur_x6_rn_x2",  2,  0,  1,  0,  6,  1, 1, 0,  0,    2'b01, 2'b00, 1, 1'b0);
      drive(5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      e = '{cyc: cyc, name: "async_reset", chk_comb: 1'b1, stall: 1'b0,
            bubble: 1'b0, chk_reg: 1'b1, fa: 2'b00, fb: 2'b00, cnt: 0};
      sb.push_back(e);
      #2 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;

      // No producers survive reset.
      issue("post_rst_nop",   0,  0,  0,  0,  0,  0, 0, 0,  0,    2'b00, 2'b00, 0);
      issue("post_rst_rd",    6,  2,  1,  1,  0,  0, 0, 0,  0,    2'b00, 2'b00, 0);

      // Counter saturation: LDUR X2, [X2] held in decode stalls every other
      // cycle (odd k); even k > 0 forwards the load from MEM/WB.
      n_stalls = (1 << CNT_W) + 5;
      stalls_so_far = 0;
      for (int k = 0; k <= 2 * n_stalls; k++) begin
         logic       st;
         logic [1:0] fa;
         st = (k % 2) == 1;
         fa = (st || k == 0) ? 2'b00 : 2'b10;
         if (st) stalls_so_far++;
         issue("sat", 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0,
               st, fa, 2'b00, (stalls_so_far > SAT) ? SAT : stalls_so_far);
      end
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
      $fatal(1, "watchdog timeout");
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller beside the ID/EX/MEM/WB control registers. It tracks the destination register and write/load flags of the instructions in EX, MEM and WB using its own shadow pipeline. From the decode-stage operands it produces a combinational load-use stall and a bubble request, plus registered forwarding selects that the EX-stage operand muxes consume. It also keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- Rn_0  in  5  decode-stage first source register
- Rm_0  in  5  decode-stage second source register
- useRn_0  in  1  decode instruction reads Rn
- useRm_0  in  1  decode instruction reads Rm
- Rd_0  in  5  decode-stage destination register
- RegWrite_0  in  1  decode instruction writes Rd
- MemRead_0  in  1  decode instruction is a load
- flush  in  1  taken branch; kill the instruction currently in decode
- stall  out  1  combinational; hold PC and IF/ID, insert bubble
- bubble  out  1  combinational; zero the ID/EX control bus this cycle (= stall | flush)
- fwdA  out  2  registered; EX operand A select: 00 regfile Da, 01 EX/MEM ALU_Out, 10 MEM/WB writeback data
- fwdB  out  2  registered; same encoding for operand B / Db
- stallCount  out  CNT_W  saturating count of stall cycles

## Operation
- The shadow pipeline holds three slots: EX {Rd, RegWrite, MemRead}, MEM {Rd, RegWrite}, WB {Rd, RegWrite}. Every cycle EX→MEM→WB shift unconditionally.
- EX slot load value: decode {Rd_0, RegWrite_0, MemRead_0}. When bubble=1, the EX slot loads {0, 0, 0} instead.
- A source is "live" when its use flag is 1 and the register is not 31. X31 (XZR) never matches, never stalls and never forwards.
- A producer matches a live source when its RegWrite=1, its Rd equals the source, and its Rd is not 31.
- Load-use stall: stall=1 iff the EX slot has MemRead=1 and matches either live source, and flush=0.
- Forward select, computed from the decode operands and registered into fwdA/fwdB:
  - EX slot matches and it is not a load → 01 (the value will sit in EX/MEM).
  - Otherwise the MEM slot matches → 10 (the value will sit in MEM/WB).
  - Otherwise → 00.
  - EX has priority over MEM, so the youngest producer wins.
- A producer in the WB slot at decode time is not forwarded. The register file writes through in the same cycle, so the read in decode already returns the new value.
- When bubble=1, the registered fwdA/fwdB load 00.
- Stall cycle behaviour: the decode instruction is held. The next cycle the load has moved to MEM, so the re-evaluated decode gives select 10 and stall=0. A stall therefore lasts exactly 1 cycle per load-use pair.
- flush=1 forces stall=0 and bubble=1. Flush wins over a simultaneous stall.
- stallCount increments on every cycle with stall=1 and saturates at all-ones. It is cleared only by reset.

## Timing
- Reset (reset=0, asynchronous): all shadow slots go to zero, fwdA=fwdB=00, stallCount=0. stall and bubble follow their combinational equations on the zeroed state, so they are 0 unless flush=1.
- Reset deasserted mid-stream: the pipeline restarts with no pending producers, so no forwarding occurs until new writers reach EX.
- Latency: stall and bubble are same-cycle from the decode inputs. fwdA/fwdB are valid in the cycle after decode, aligned with the ID/EX register outputs Da/Db/ALUOp.
- A producer reaches the EX slot one clock after its decode, MEM after two, WB after three.
- Back-to-back dependent ALU ops need no stall, since 01 forwarding is available the following cycle.
- Load followed by dependent instruction: 1 stall cycle, then select 10.
- Load followed by independent instruction, then dependent: no stall, select 10.

## Test plan
- ADD X1 ← …, then SUB reading Rn=X1 next cycle → stall=0; fwdA=01 one cycle after the SUB decode; fwdB=00.
- LDUR X2, then ADD with Rm=X2 → stall=1 for exactly 1 cycle; bubble=1; EX slot is zero; then fwdB=10; stallCount=1.
- Writer of X3 in both the EX and MEM slots, decode reads X3 on both operands → fwdA=fwdB=01 (youngest producer wins).
- Writer to X31, then reader of X31; and a load to X31, then reader of X31 → stall=0 and fwdA=00 in both cases.
- Load-use hazard with flush=1 in the same cycle → stall=0, bubble=1, fwd=00, stallCount unchanged.
- Drive reset=0 mid-stall between clock edges → all outputs clear immediately; 2^CNT_W+5 forced stall cycles → stallCount holds at all-ones.
